// File: rtl/sample_rec_pkg.sv
// rtl/sample_rec_pkg.sv - shared types and default widths for the sample recorder
//
// Purpose : recorder FSM state encoding and default geometry constants.
// Ports   : none (package).
// Options : none here; see sample_recorder.sv for LEVEL_TRIG_EN.

package sample_rec_pkg;

   localparam int DEF_ADDRESS_WIDTH = 8;
   localparam int DEF_DATA_WIDTH    = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      RECORD = 2'd2,
      DONE   = 2'd3
   } rec_state_t;

endpackage

// File: rtl/sync_dp_ram.sv
// rtl/sync_dp_ram.sv - simple dual-port RAM, one write port, one registered read port
//
// Purpose : capture storage for the sample recorder.
// Ports   :
//   clk      - system clock, all logic on posedge
//   rst      - synchronous active-high reset, clears only the read register
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address, sampled every edge
//   rd_data  - registered read data, one cycle latency
// A read and a write to the same address on the same edge return the
// contents from before the write (read-before-write).

module sync_dp_ram
   import sample_rec_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ADDRESS_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]    rd_data
);

   localparam int DEPTH = 1 << ADDRESS_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   // Array contents survive reset so a captured burst can still be read
   // back after the controller has been reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Non-blocking read of the array gives the pre-write value on collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sample_recorder.sv
// rtl/sample_recorder.sv - triggered burst capture of a sample stream into RAM
//
// Purpose : arm on start, wait for a trigger, then write one sample per
//           valid beat from address 0 to the last address, then stop.
//           Captured data is read back through a one-cycle registered port.
// Ports   :
//   clk        - system clock, all logic on posedge
//   rst        - synchronous active-high reset (RAM contents kept)
//   start      - arm request, honoured in IDLE and DONE
//   trig       - external trigger, qualified by din_valid in ARMED
//   din_valid  - din carries a new sample this cycle
//   din        - incoming sample
//   trig_level - (LEVEL_TRIG_EN only) rising-crossing threshold, unsigned
//   rd_addr    - readback address
//   rd_data    - readback data, registered
//   wr_count   - samples written in the current or last burst
//   busy       - high in ARMED or RECORD
//   done       - high in DONE
// Options : define LEVEL_TRIG_EN to add the level-crossing trigger.

module sample_recorder
   import sample_rec_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     trig,
   input  logic                     din_valid,
   input  logic [DATA_WIDTH-1:0]    din,
`ifdef LEVEL_TRIG_EN
   input  logic [DATA_WIDTH-1:0]    trig_level,
`endif
   input  logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic [ADDRESS_WIDTH:0]   wr_count,
   output logic                     busy,
   output logic                     done
);

   localparam logic [ADDRESS_WIDTH:0] CNT_ONE = (ADDRESS_WIDTH+1)'(1);

   rec_state_t                state;
   rec_state_t                state_nx;
   logic                      trig_hit;
   logic                      last_addr;
   logic                      ram_we;
   logic [ADDRESS_WIDTH-1:0]  ram_wr_addr;

   // ------------------------------------------------------------------
   // Trigger qualification
   // ------------------------------------------------------------------
`ifdef LEVEL_TRIG_EN
   logic [DATA_WIDTH-1:0] prev_sample;

   // Tracks the last valid sample in every state so the first sample
   // seen after arming is compared against real history.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_sample <= '0;
      end else if (din_valid) begin
         prev_sample <= din;
      end
   end

   assign trig_hit = din_valid &&
                     (trig || ((prev_sample < trig_level) && (din >= trig_level)));
`else
   assign trig_hit = din_valid && trig;
`endif

   // The write in RECORD lands at wr_count; all-ones there is the final slot.
   assign last_addr = (wr_count[ADDRESS_WIDTH-1:0] == {ADDRESS_WIDTH{1'b1}});

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = ARMED;
            end
         end
         ARMED: begin
            if (trig_hit) begin
               state_nx = RECORD;
            end
         end
         RECORD: begin
            if (din_valid && last_addr) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            if (start) begin
               state_nx = ARMED;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs and RAM write control
   // ------------------------------------------------------------------
   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      ram_we      = 1'b0;
      ram_wr_addr = wr_count[ADDRESS_WIDTH-1:0];
      case (state)
         ARMED: begin
            busy        = 1'b1;
            ram_we      = trig_hit;
            ram_wr_addr = '0;
         end
         RECORD: begin
            busy   = 1'b1;
            ram_we = din_valid;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Write counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_count <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  wr_count <= '0;
               end
            end
            ARMED: begin
               if (trig_hit) begin
                  wr_count <= CNT_ONE;
               end
            end
            RECORD: begin
               if (din_valid) begin
                  wr_count <= wr_count + CNT_ONE;
               end
            end
            default: wr_count <= '0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Capture storage
   // ------------------------------------------------------------------
   sync_dp_ram #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (ram_we),
      .wr_addr (ram_wr_addr),
      .wr_data (din),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule
